pc_sequencer: RTL and testbench

Parametrised next-generation program-counter unit for the single-cycle core, sitting between the branch-condition flags from the ALU and the instruction-memory address port. It keeps the codebase's flag/condition branch semantics and adds configurable address width, relative or absolute immediate targets, pipeline stall, and a circular return-address stack (RAS) for call/return. A two-state halt machine replaces level-only halting.

---
 rtl/pc_seq_if.sv | 41 ++++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_seq_if: bundle between the core's control/ALU side and the PC sequencer.
//   Control -> sequencer: AddrSrc, InAddrImm, InAddrReg, branch, cond, Z, N, V,
//                         call, ret, stall, hlt
//   Sequencer -> control: OutAddr, PCSOut, halted, ras_empty, ras_full,
//                         ras_underflow
// The master modport is the side that issues control; the slave modport is the
// PC sequencer itself.
interface pc_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             AddrSrc;
  logic [WIDTH-1:0] InAddrImm;
  logic [WIDTH-1:0] InAddrReg;
  logic             branch;
  logic [2:0]       cond;
  logic             Z;
  logic             N;
  logic             V;
  logic             call;
  logic             ret;
  logic             stall;
  logic             hlt;
  logic [WIDTH-1:0] OutAddr;
  logic [WIDTH-1:0] PCSOut;
  logic             halted;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output AddrSrc, InAddrImm, InAddrReg, branch, cond, Z, N, V,
           call, ret, stall, hlt,
    input  OutAddr, PCSOut, halted, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  AddrSrc, InAddrImm, InAddrReg, branch, cond, Z, N, V,
           call, ret, stall, hlt,
    output OutAddr, PCSOut, halted, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit with conditional branches, relative or
// absolute immediate targets, stall, halt state and a circular return-address
// stack (RAS).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_seq_if.slave: branch/call/ret/stall/hlt controls, flags and
//          targets in; OutAddr (registered PC), PCSOut (PC + STEP), halted,
//          ras_empty/ras_full (from entry count) and ras_underflow pulse out.
module pc_sequencer #(
  parameter int WIDTH      = 16,
  parameter int STEP       = 2,
  parameter int RESET_VEC  = 0,
  parameter int REL_BRANCH = 0,
  parameter int RAS_DEPTH  = 4
) (
  input logic    clk,
  input logic    rst,
  pc_seq_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] sp_q, sp_d;      // next free slot; top is sp_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;    // valid entries, saturates at RAS_DEPTH
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;

  logic [WIDTH-1:0] pcs, imm_sh, imm_target, target, ras_top;
  logic [PTR_W-1:0] top_idx;
  logic             cond_true, taken, empty, full;

  assign pcs    = pc_q + WIDTH'(STEP);
  // Halfword offset to bytes; the MSB falls off so the shift stays in WIDTH.
  assign imm_sh = {bus.InAddrImm[WIDTH-2:0], 1'b0};

  generate
    if (REL_BRANCH != 0) begin : g_rel
      assign imm_target = pcs + imm_sh;
    end else begin : g_abs
      assign imm_target = imm_sh;
    end
  endgenerate

  assign target  = bus.AddrSrc ? imm_target : bus.InAddrReg;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_idx = sp_q - PTR_W'(1);
  assign ras_top = ras_mem[top_idx];

  // "Always" ignores the flags entirely so undriven flags cannot block it.
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000:  cond_true = !bus.Z;
      3'b001:  cond_true = bus.Z;
      3'b010:  cond_true = !bus.Z && !bus.N;
      3'b011:  cond_true = bus.N;
      3'b100:  cond_true = bus.Z || !bus.N;
      3'b101:  cond_true = bus.Z || bus.N;
      3'b110:  cond_true = bus.V;
      default: cond_true = 1'b1;
    endcase
  end

  assign taken = bus.branch && cond_true;

  always_comb begin
    // hlt is honoured in both states: it enters/keeps HALT and freezes the PC;
    // leaving HALT is just the first cycle with hlt low, which runs normally.
    state_d     = bus.hlt ? ST_HALT : ST_RUN;
    pc_d        = pc_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    ras_we      = 1'b0;
    ras_waddr   = sp_q;
    if (!bus.hlt && !bus.stall) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d        = pcs;
          underflow_d = 1'b1;
          if (bus.call) begin
            ras_we = 1'b1;
            sp_d   = sp_q + PTR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else begin
          pc_d = ras_top;
          if (bus.call) begin
            // Call+return: swap the top entry in place, depth unchanged.
            ras_we    = 1'b1;
            ras_waddr = top_idx;
          end else begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end else if (taken) begin
        pc_d = target;
        if (bus.call) begin
          // When full the write lands on the oldest slot, overwriting it.
          ras_we = 1'b1;
          sp_d   = sp_q + PTR_W'(1);
          cnt_d  = full ? cnt_q : cnt_q + CNT_W'(1);
        end
      end else begin
        pc_d = pcs;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= WIDTH'(RESET_VEC);
      sp_q        <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents need no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem[ras_waddr] <= pcs;
    end
  end

  assign bus.OutAddr       = pc_q;
  assign bus.PCSOut        = pcs;
  assign bus.halted        = (state_q == ST_HALT);
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer. Three instances
// share one stimulus: default parameters (dut_a), WIDTH=8 with RESET_VEC=254
// (dut_w, wrap-around) and REL_BRANCH=1 (dut_r, relative immediates).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        addr_src, branch, call, ret, stall, hlt;
  logic [2:0]  cond;
  logic        z, n, v;
  logic [15:0] imm, reg_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_seq_if #(.WIDTH(16)) if_a ();
  pc_seq_if #(.WIDTH(8))  if_w ();
  pc_seq_if #(.WIDTH(16)) if_r ();

  assign if_a.AddrSrc = addr_src; assign if_a.InAddrImm = imm; assign if_a.InAddrReg = reg_t;
  assign if_a.branch = branch; assign if_a.cond = cond; assign if_a.Z = z; assign if_a.N = n;
  assign if_a.V = v; assign if_a.call = call; assign if_a.ret = ret; assign if_a.stall = stall;
  assign if_a.hlt = hlt;

  assign if_w.AddrSrc = addr_src; assign if_w.InAddrImm = imm[7:0]; assign if_w.InAddrReg = reg_t[7:0];
  assign if_w.branch = branch; assign if_w.cond = cond; assign if_w.Z = z; assign if_w.N = n;
  assign if_w.V = v; assign if_w.call = call; assign if_w.ret = ret; assign if_w.stall = stall;
  assign if_w.hlt = hlt;

  assign if_r.AddrSrc = addr_src; assign if_r.InAddrImm = imm; assign if_r.InAddrReg = reg_t;
  assign if_r.branch = branch; assign if_r.cond = cond; assign if_r.Z = z; assign if_r.N = n;
  assign if_r.V = v; assign if_r.call = call; assign if_r.ret = ret; assign if_r.stall = stall;
  assign if_r.hlt = hlt;

  pc_sequencer #(.WIDTH(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  pc_sequencer #(.WIDTH(8), .RESET_VEC(254)) dut_w (.clk(clk), .rst(rst), .bus(if_w.slave));
  pc_sequencer #(.WIDTH(16), .REL_BRANCH(1)) dut_r (.clk(clk), .rst(rst), .bus(if_r.slave));

  // {cond[2:0], Z, N, V, branch, expected_taken}
  logic [7:0] cvec [16] = '{
    8'b000_000_1_1, 8'b000_100_1_0, 8'b001_100_1_1, 8'b001_000_1_0,
    8'b010_000_1_1, 8'b010_010_1_0, 8'b011_010_1_1, 8'b011_100_1_0,
    8'b100_110_1_1, 8'b100_010_1_0, 8'b101_010_1_1, 8'b101_000_1_0,
    8'b110_001_1_1, 8'b110_110_1_0, 8'b111_000_1_1, 8'b111_000_0_0
  };

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    addr_src = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0; hlt = 1'b0;
    cond = 3'b000; z = 1'b0; n = 1'b0; v = 1'b0; imm = '0; reg_t = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("[%0t] pc_a=%h pc_w=%h pc_r=%h halted=%b empty=%b full=%b uf=%b", $time,
             if_a.OutAddr, if_w.OutAddr, if_r.OutAddr, if_a.halted,
             if_a.ras_empty, if_a.ras_full, if_a.ras_underflow);
  endtask

  // Taken unconditional jump to a register target, optionally a call.
  task automatic jump_reg(input logic [15:0] t, input logic is_call);
    idle();
    branch = 1'b1; cond = 3'b111; reg_t = t; call = is_call;
    tick();
  endtask

  task automatic do_ret();
    idle();
    ret = 1'b1;
    tick();
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] ret_exp [4];
    ret_exp = '{16'h0402, 16'h0302, 16'h0202, 16'h0102};

    idle();
    rst = 1'b1;
    #1;
    check_eq("rst_pc", if_a.OutAddr, 16'h0000);
    check_eq("rst_pcs", if_a.PCSOut, 16'h0002);
    check_eq("rst_halted", if_a.halted, 1'b0);
    check_eq("rst_empty", if_a.ras_empty, 1'b1);
    check_eq("rst_full", if_a.ras_full, 1'b0);
    check_eq("rst_uf", if_a.ras_underflow, 1'b0);
    check_eq("rst_w8_pc", if_w.OutAddr, 8'd254);
    check_eq("rst_w8_pcs", if_w.PCSOut, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    tick();
    check_eq("seq1", if_a.OutAddr, 16'd2);
    check_eq("w8_wrap", if_w.OutAddr, 8'd0);
    tick();
    check_eq("seq2", if_a.OutAddr, 16'd4);

    // Every condition code, taken and not taken; target = (5+i)*2.
    exp_pc = 16'd4;
    for (int i = 0; i < 16; i++) begin
      idle();
      addr_src = 1'b1;
      cond = cvec[i][7:5]; z = cvec[i][4]; n = cvec[i][3]; v = cvec[i][2];
      branch = cvec[i][1];
      if (cvec[i][7:5] == 3'b111 && cvec[i][1]) begin
        z = 1'bx; n = 1'bx; v = 1'bx;
      end
      imm = 16'(5 + i);
      tick();
      exp_pc = cvec[i][0] ? 16'((5 + i) * 2) : exp_pc + 16'd2;
      check_eq($sformatf("cond%0d", i), if_a.OutAddr, exp_pc);
    end

    // Return-address stack.
    jump_reg(16'd8, 1'b0);
    check_eq("ras_pre", if_a.OutAddr, 16'd8);
    jump_reg(16'h0040, 1'b1);
    check_eq("call_pc", if_a.OutAddr, 16'h0040);
    check_eq("call_nonempty", if_a.ras_empty, 1'b0);
    do_ret();
    check_eq("ret_pc", if_a.OutAddr, 16'd10);
    check_eq("ret_empty", if_a.ras_empty, 1'b1);
    check_eq("ret_uf0", if_a.ras_underflow, 1'b0);
    do_ret();
    check_eq("uf_pc", if_a.OutAddr, 16'd12);
    check_eq("uf_pulse", if_a.ras_underflow, 1'b1);
    idle();
    tick();
    check_eq("uf_clear", if_a.ras_underflow, 1'b0);
    check_eq("uf_seq", if_a.OutAddr, 16'd14);

    for (int k = 1; k <= 5; k++) begin
      jump_reg(16'(k * 16'h0100), 1'b1);
      check_eq($sformatf("call%0d_pc", k), if_a.OutAddr, 16'(k * 16'h0100));
      if (k == 3) check_eq("not_full3", if_a.ras_full, 1'b0);
      if (k >= 4) check_eq($sformatf("full%0d", k), if_a.ras_full, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      do_ret();
      check_eq($sformatf("unwind%0d", k), if_a.OutAddr, ret_exp[k]);
    end
    check_eq("unwind_empty", if_a.ras_empty, 1'b1);
    do_ret();
    check_eq("oldest_lost", if_a.OutAddr, 16'h0104);
    check_eq("oldest_uf", if_a.ras_underflow, 1'b1);

    // Call and return in the same cycle.
    jump_reg(16'h0600, 1'b1);
    check_eq("cr_pre", if_a.OutAddr, 16'h0600);
    idle();
    branch = 1'b1; cond = 3'b111; reg_t = 16'h0700; call = 1'b1; ret = 1'b1;
    tick();
    check_eq("cr_pc", if_a.OutAddr, 16'h0106);
    check_eq("cr_depth", if_a.ras_empty, 1'b0);
    do_ret();
    check_eq("cr_swapped", if_a.OutAddr, 16'h0602);
    check_eq("cr_empty", if_a.ras_empty, 1'b1);

    // Stall holds PC and stack even with a taken call.
    idle();
    branch = 1'b1; cond = 3'b111; reg_t = 16'h0700; call = 1'b1; stall = 1'b1;
    tick();
    check_eq("stall_pc", if_a.OutAddr, 16'h0602);
    check_eq("stall_ras", if_a.ras_empty, 1'b1);
    idle();
    tick();
    check_eq("stall_release", if_a.OutAddr, 16'h0604);
    check_eq("stall_nopush", if_a.ras_empty, 1'b1);

    // Halt.
    jump_reg(16'd100, 1'b0);
    idle();
    hlt = 1'b1;
    tick();
    check_eq("hlt_pc", if_a.OutAddr, 16'd100);
    check_eq("hlt_halted", if_a.halted, 1'b1);
    tick();
    check_eq("hlt_hold", if_a.OutAddr, 16'd100);
    idle();
    tick();
    check_eq("resume_pc", if_a.OutAddr, 16'd102);
    check_eq("resume_halted", if_a.halted, 1'b0);

    // Asynchronous reset while halted with three stacked returns.
    jump_reg(16'h0010, 1'b1);
    jump_reg(16'h0020, 1'b1);
    jump_reg(16'h0030, 1'b1);
    idle();
    hlt = 1'b1;
    tick();
    check_eq("pre_rst_halted", if_a.halted, 1'b1);
    check_eq("pre_rst_ras", if_a.ras_empty, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("arst_pc", if_a.OutAddr, 16'd0);
    check_eq("arst_halted", if_a.halted, 1'b0);
    check_eq("arst_empty", if_a.ras_empty, 1'b1);
    check_eq("arst_pcs", if_a.PCSOut, 16'd2);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst_pc", if_a.OutAddr, 16'd2);

    // Relative vs absolute immediate targets.
    jump_reg(16'd10, 1'b0);
    check_eq("rel_pre", if_r.OutAddr, 16'd10);
    idle();
    branch = 1'b1; cond = 3'b111; addr_src = 1'b1; imm = 16'd3;
    tick();
    check_eq("rel_imm", if_r.OutAddr, 16'd18);
    check_eq("abs_imm", if_a.OutAddr, 16'd6);
    jump_reg(16'h0040, 1'b0);
    check_eq("rel_reg", if_r.OutAddr, 16'h0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
